// File: rtl/regset_mp.sv
// Multi-port register set: two write lanes, two combinational read ports, per-register busy scoreboard.
// Optional write-to-read forwarding is enabled by defining REGSET_BYPASS_EN.
module regset_mp #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic [WIDTH-1:0]  D0,
  input  logic [WIDTH-1:0]  D1,
  input  logic [ADDR_W-1:0] A_D0,
  input  logic [ADDR_W-1:0] A_D1,
  input  logic              write_enable0,
  input  logic              write_enable1,
  input  logic [ADDR_W-1:0] A_Q0,
  input  logic [ADDR_W-1:0] A_Q1,
  output logic [WIDTH-1:0]  Q0,
  output logic [WIDTH-1:0]  Q1,
  input  logic              mark_enable,
  input  logic [ADDR_W-1:0] A_M,
  output logic              BUSY0,
  output logic              BUSY1
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             wr0_ok;
  logic             wr1_ok;
  logic             mark_ok;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wr0_ok  = write_enable0 && !is_zero(A_D0);
  assign wr1_ok  = write_enable1 && !is_zero(A_D1);
  assign mark_ok = mark_enable && !is_zero(A_M);

  // Statement order gives lane 1 priority over lane 0, and a mark priority over a write's busy clear.
  always_ff @(posedge CLK) begin
    if (RES) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr0_ok) begin
        regs[A_D0] <= D0;
        busy[A_D0] <= 1'b0;
      end
      if (wr1_ok) begin
        regs[A_D1] <= D1;
        busy[A_D1] <= 1'b0;
      end
      if (mark_ok) begin
        busy[A_M] <= 1'b1;
      end
    end
  end

  always_comb begin
    Q0 = regs[A_Q0];
`ifdef REGSET_BYPASS_EN
    if (!RES && wr0_ok && (A_D0 == A_Q0)) Q0 = D0;
    if (!RES && wr1_ok && (A_D1 == A_Q0)) Q0 = D1;
`endif
    if (is_zero(A_Q0)) Q0 = '0;
  end

  always_comb begin
    Q1 = regs[A_Q1];
`ifdef REGSET_BYPASS_EN
    if (!RES && wr0_ok && (A_D0 == A_Q1)) Q1 = D0;
    if (!RES && wr1_ok && (A_D1 == A_Q1)) Q1 = D1;
`endif
    if (is_zero(A_Q1)) Q1 = '0;
  end

  // Busy is never forwarded; it reflects stored state only.
  assign BUSY0 = busy[A_Q0] && !is_zero(A_Q0);
  assign BUSY1 = busy[A_Q1] && !is_zero(A_Q1);

endmodule

// File: tb/tb_regset_mp.sv
// Self-checking bench for regset_mp: directed vector table, corner sequences and random traffic
// compared against an array-based reference model.
module tb_regset_mp;

`ifdef REGSET_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RES;
  logic [31:0] D0, D1;
  logic [4:0]  A_D0, A_D1, A_Q0, A_Q1, A_M;
  logic        write_enable0, write_enable1, mark_enable;
  logic [31:0] Q0, Q1;
  logic        BUSY0, BUSY1;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [31:0] model_regs [32];
  bit          model_busy [32];

  typedef struct {
    logic        we0;
    logic [4:0]  a_d0;
    logic [31:0] d0;
    logic        we1;
    logic [4:0]  a_d1;
    logic [31:0] d1;
    logic        me;
    logic [4:0]  a_m;
    logic        res;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [4:0]  qa0;
    logic [4:0]  qa1;
    logic [31:0] e_q0;
    logic [31:0] e_q1;
    logic        e_b0;
    logic        e_b1;
  } vec_t;

  vec_t vecs [10];

  regset_mp #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .CLK(CLK), .RES(RES),
    .D0(D0), .D1(D1), .A_D0(A_D0), .A_D1(A_D1),
    .write_enable0(write_enable0), .write_enable1(write_enable1),
    .A_Q0(A_Q0), .A_Q1(A_Q1), .Q0(Q0), .Q1(Q1),
    .mark_enable(mark_enable), .A_M(A_M),
    .BUSY0(BUSY0), .BUSY1(BUSY1)
  );

  always #5 CLK = ~CLK;

  function automatic stim_t mk(input logic we0, input logic [4:0] a_d0, input logic [31:0] d0,
                               input logic we1, input logic [4:0] a_d1, input logic [31:0] d1,
                               input logic me, input logic [4:0] a_m, input logic res);
    stim_t s;
    s.we0 = we0; s.a_d0 = a_d0; s.d0 = d0;
    s.we1 = we1; s.a_d1 = a_d1; s.d1 = d1;
    s.me = me; s.a_m = a_m; s.res = res;
    return s;
  endfunction

  // Reference behaviour: reset clears everything; address 0 is immune; later lane wins; mark beats clear.
  function automatic void model_update(input stim_t s);
    if (s.res) begin
      for (int i = 0; i < 32; i++) begin
        model_regs[i] = '0;
        model_busy[i] = 1'b0;
      end
    end else begin
      if (s.we0 && s.a_d0 != 0) begin model_regs[s.a_d0] = s.d0; model_busy[s.a_d0] = 1'b0; end
      if (s.we1 && s.a_d1 != 0) begin model_regs[s.a_d1] = s.d1; model_busy[s.a_d1] = 1'b0; end
      if (s.me && s.a_m != 0) model_busy[s.a_m] = 1'b1;
    end
  endfunction

  function automatic logic [31:0] exp_q(input stim_t s, input logic [4:0] a);
    if (a == 0) return '0;
    if (BYP && !s.res) begin
      if (s.we1 && s.a_d1 == a) return s.d1;
      if (s.we0 && s.a_d0 == a) return s.d0;
    end
    return model_regs[a];
  endfunction

  task automatic drive(input stim_t s);
    write_enable0 = s.we0; A_D0 = s.a_d0; D0 = s.d0;
    write_enable1 = s.we1; A_D1 = s.a_d1; D1 = s.d1;
    mark_enable = s.me; A_M = s.a_m; RES = s.res;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    @(negedge CLK);
    drive(s);
    @(posedge CLK);
    model_update(s);
    #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic checkOutput(input string name, input logic [4:0] qa0, input logic [4:0] qa1,
                             input logic [31:0] eq0, input logic [31:0] eq1,
                             input logic eb0, input logic eb1);
    A_Q0 = qa0;
    A_Q1 = qa1;
    #1;
    cmp({name, ".Q0"}, Q0, eq0);
    cmp({name, ".Q1"}, Q1, eq1);
    cmp({name, ".BUSY0"}, {31'b0, BUSY0}, {31'b0, eb0});
    cmp({name, ".BUSY1"}, {31'b0, BUSY1}, {31'b0, eb1});
  endtask

  initial begin
    stim_t s;
    logic [4:0] ra0, ra1;

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    A_Q0 = 0; A_Q1 = 0;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    checkOutput("reset", 7, 31, 32'h0, 32'h0, 1'b0, 1'b0);

    // Fill every register with ones and mark the upper half busy, then reset with writes pending.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(mk(1, 5'(i), 32'hFFFF_FFFF, 1, 5'(i + 16), 32'hFFFF_FFFF, 1, 5'(i + 16), 0));
    end
    checkOutput("prefill", 31, 0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    applyStimulus(mk(1, 3, 32'hFFFF_FFFF, 1, 20, 32'hFFFF_FFFF, 1, 21, 1));
    for (int i = 0; i < 32; i++) begin
      checkOutput("reset_sweep", 5'(i), 5'(31 - i), 32'h0, 32'h0, 1'b0, 1'b0);
    end

    vecs[0] = '{mk(1, 12, 103, 1, 7, 69, 0, 0, 0), 12, 7, 103, 69, 0, 0};
    vecs[1] = '{mk(1, 5, 11, 1, 5, 22, 0, 0, 0), 5, 5, 22, 22, 0, 0};
    vecs[2] = '{mk(0, 12, 69, 0, 0, 0, 0, 0, 0), 12, 7, 103, 69, 0, 0};
    vecs[3] = '{mk(1, 0, 55, 0, 0, 0, 0, 0, 0), 0, 12, 0, 103, 0, 0};
    vecs[4] = '{mk(0, 0, 0, 0, 0, 0, 1, 9, 0), 9, 9, 0, 0, 1, 1};
    vecs[5] = '{mk(0, 0, 0, 1, 9, 4, 0, 0, 0), 9, 5, 4, 22, 0, 0};
    vecs[6] = '{mk(1, 9, 50, 0, 0, 0, 1, 9, 0), 9, 12, 50, 103, 1, 0};
    vecs[7] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0), 0, 9, 0, 50, 0, 1};
    vecs[8] = '{mk(1, 4, 8, 1, 9, 7, 1, 4, 1), 4, 9, 0, 0, 0, 0};
    vecs[9] = '{mk(0, 0, 0, 1, 4, 8, 0, 0, 0), 4, 12, 8, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].s);
      checkOutput($sformatf("vec%0d", i), vecs[i].qa0, vecs[i].qa1,
                  vecs[i].e_q0, vecs[i].e_q1, vecs[i].e_b0, vecs[i].e_b1);
    end

    // Same-cycle forwarding, lane priority, and the reset / register-0 exceptions, all sampled with CLK low.
    applyStimulus(mk(1, 3, 10, 0, 0, 0, 0, 0, 0));
    checkOutput("byp_pre", 3, 3, 10, 10, 0, 0);
    @(negedge CLK);
    drive(mk(1, 3, 77, 0, 0, 0, 0, 0, 0));
    checkOutput("byp_lane0", 3, 4, BYP ? 32'd77 : 32'd10, 8, 0, 0);
    s = mk(1, 3, 77, 1, 3, 88, 0, 0, 0);
    drive(s);
    checkOutput("byp_prio", 3, 3, BYP ? 32'd88 : 32'd10, BYP ? 32'd88 : 32'd10, 0, 0);
    @(posedge CLK);
    model_update(s);
    #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("byp_post", 3, 3, 88, 88, 0, 0);
    @(negedge CLK);
    s = mk(1, 3, 99, 1, 3, 99, 0, 0, 1);
    drive(s);
    checkOutput("byp_res", 3, 3, 88, 88, 0, 0);
    @(posedge CLK);
    model_update(s);
    #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("byp_res_post", 3, 4, 0, 0, 0, 0);
    @(negedge CLK);
    s = mk(1, 0, 5, 1, 0, 6, 1, 0, 0);
    drive(s);
    checkOutput("byp_zero", 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    model_update(s);
    #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("byp_zero_post", 0, 0, 0, 0, 0, 0);

    // Random traffic on a narrow address window so collisions between lanes and marks are common.
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      s = mk(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom), 5'($urandom_range(0, 7)), ($urandom_range(0, 29) == 0));
      drive(s);
      ra0 = 5'($urandom_range(0, 7));
      ra1 = 5'($urandom_range(0, 31));
      checkOutput("rand_pre", ra0, ra1, exp_q(s, ra0), exp_q(s, ra1),
                  model_busy[ra0], model_busy[ra1]);
      @(posedge CLK);
      model_update(s);
      #1;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      ra0 = 5'($urandom_range(0, 7));
      ra1 = 5'($urandom_range(0, 7));
      checkOutput("rand_post", ra0, ra1, model_regs[ra0], model_regs[ra1],
                  model_busy[ra0], model_busy[ra1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
